// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multi-cycle controller and instruction/data memory.
// Controller side uses the master modport, memory side the slave modport.
interface multicycle_control_unit_if;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    input  instr,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    output instr,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 controller: FETCH/DECODE/EXEC/MEM/WB with memory handshakes and traps.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus,
  input  logic                        zero,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_src,
  output logic                        reg2loc,
  output logic                        alu_src,
  output logic                        mem2reg,
  output logic                        reg_write,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [3:0]                  alu_signal,
  output logic [2:0]                  state,
  output logic                        retire,
  output logic                        trap,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CNT_W-1:0]            retire_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_ADD, CL_SUB, CL_AND, CL_ORR,
    CL_LDUR, CL_STUR, CL_CBZ, CL_CBNZ, CL_B
  } class_t;

  localparam int unsigned   TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  class_t        r_class;
  class_t        w_dec;
  logic [10:0]   r_op;
  logic [TW-1:0] r_tmo;
  logic          r_trap;
  logic          w_tmo_hit;

  logic w_imem_req, w_dmem_req, w_ir_write, w_pc_write, w_pc_src, w_reg2loc;
  logic w_alu_src, w_mem2reg, w_reg_write, w_mem_read, w_mem_write, w_retire;
  logic [3:0] w_alu;

  // The waiting cycle that would make MEM_TIMEOUT unacknowledged cycles is the expiry cycle.
  assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_tmo == TMO_LAST);

  always_comb begin
    w_dec = CL_NONE;
    if      (r_op == 11'b10001011000) w_dec = CL_ADD;
    else if (r_op == 11'b11001011000) w_dec = CL_SUB;
    else if (r_op == 11'b10001010000) w_dec = CL_AND;
    else if (r_op == 11'b10101010000) w_dec = CL_ORR;
    else if (r_op == 11'b11111000010) w_dec = CL_LDUR;
    else if (r_op == 11'b11111000000) w_dec = CL_STUR;
    else if (r_op[10:3] == 8'b10110100) w_dec = CL_CBZ;
    else if (r_op[10:3] == 8'b10110101) w_dec = CL_CBNZ;
    else if (r_op[10:5] == 6'b000101)   w_dec = CL_B;
  end

  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 1'b0;
    w_reg2loc   = 1'b0;
    w_alu_src   = 1'b0;
    w_mem2reg   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_retire    = 1'b0;
    w_alu       = 4'b0000;
    case (r_state)
      FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = DECODE;
        end else if (w_tmo_hit) begin
          w_next = TRAP;
        end
      end
      DECODE: w_next = (w_dec == CL_NONE) ? TRAP : EXEC;
      EXEC: begin
        case (r_class)
          CL_ADD:  begin w_alu = 4'b0010; w_next = WB; end
          CL_SUB:  begin w_alu = 4'b0110; w_next = WB; end
          CL_AND:  begin w_alu = 4'b0000; w_next = WB; end
          CL_ORR:  begin w_alu = 4'b0001; w_next = WB; end
          CL_LDUR, CL_STUR: begin
            w_alu_src = 1'b1;
            w_alu     = 4'b0010;
            w_reg2loc = (r_class == CL_STUR);
            w_next    = MEM;
          end
          CL_CBZ, CL_CBNZ: begin
            w_reg2loc = 1'b1;
            w_alu     = 4'b0111;
            w_retire  = 1'b1;
            w_next    = FETCH;
            if (zero == (r_class == CL_CBZ)) begin
              w_pc_write = 1'b1;
              w_pc_src   = 1'b1;
            end
          end
          CL_B: begin
            w_pc_write = 1'b1;
            w_pc_src   = 1'b1;
            w_retire   = 1'b1;
            w_next     = FETCH;
          end
          default: w_next = TRAP;
        endcase
      end
      MEM: begin
        w_dmem_req  = 1'b1;
        w_mem_read  = (r_class == CL_LDUR);
        w_mem_write = (r_class == CL_STUR);
        if (bus.dmem_ack) begin
          w_retire = (r_class == CL_STUR);
          w_next   = (r_class == CL_STUR) ? FETCH : WB;
        end else if (w_tmo_hit) begin
          w_next = TRAP;
        end
      end
      WB: begin
        w_reg_write = 1'b1;
        w_mem2reg   = (r_class == CL_LDUR);
        w_retire    = 1'b1;
        w_next      = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_trap  <= 1'b0;
      r_tmo   <= '0;
      r_class <= CL_NONE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == TRAP) r_trap <= 1'b1;
      if (r_state == FETCH && bus.imem_ack) r_op <= bus.instr[31:21];
      if (r_state == DECODE) r_class <= w_dec;
      if ((r_state == FETCH || r_state == MEM) && w_next == r_state && MEM_TIMEOUT != 0)
        r_tmo <= r_tmo + 1'b1;
      else
        r_tmo <= '0;
    end
  end

  assign bus.imem_req = w_imem_req  & ~reset;
  assign bus.dmem_req = w_dmem_req  & ~reset;
  assign ir_write     = w_ir_write  & ~reset;
  assign pc_write     = w_pc_write  & ~reset;
  assign pc_src       = w_pc_src    & ~reset;
  assign reg2loc      = w_reg2loc   & ~reset;
  assign alu_src      = w_alu_src   & ~reset;
  assign mem2reg      = w_mem2reg   & ~reset;
  assign reg_write    = w_reg_write & ~reset;
  assign mem_read     = w_mem_read  & ~reset;
  assign mem_write    = w_mem_write & ~reset;
  assign retire       = w_retire    & ~reset;
  assign trap         = r_trap      & ~reset;
  assign alu_signal   = reset ? 4'b0000 : w_alu;
  assign state        = reset ? 3'd0 : r_state;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      if (r_state != TRAP && r_cyc != '1) r_cyc <= r_cyc + 1'b1;
      if (w_retire && r_ret != '1)        r_ret <= r_ret + 1'b1;
    end
  end

  assign cycle_count  = reset ? '0 : r_cyc;
  assign retire_count = reset ? '0 : r_ret;
`else
  assign cycle_count  = '0;
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction expected traces built from
// the instruction latency/handshake rules, replayed cycle by cycle against the DUT.
module tb_multicycle_control_unit;
  localparam int TMO = 16;

  localparam logic [10:0] IREQ = 11'h400, DREQ = 11'h200, IRW = 11'h100, PCW = 11'h080;
  localparam logic [10:0] PCS  = 11'h040, R2L  = 11'h020, ASRC = 11'h010, M2R = 11'h008;
  localparam logic [10:0] RW   = 11'h004, MRD  = 11'h002, MWR  = 11'h001;

  localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_ORR = 3, C_LDUR = 4;
  localparam int C_STUR = 5, C_CBZ = 6, C_CBNZ = 7, C_B = 8, C_ILL = 9;

  typedef struct {
    logic        rst, iack, dack, z;
    logic [31:0] ins;
    logic [2:0]  st;
    logic [10:0] ctl;
    logic [3:0]  alu;
    logic        ret, trp;
    logic [31:0] cc, rc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic zero = 1'b0;
  logic ir_write, pc_write, pc_src, reg2loc, alu_src, mem2reg, reg_write, mem_read, mem_write;
  logic [3:0]  alu_signal;
  logic [2:0]  state;
  logic        retire, trap;
  logic [31:0] cycle_count, retire_count;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc),
    .alu_src(alu_src), .mem2reg(mem2reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_signal(alu_signal), .state(state), .retire(retire),
    .trap(trap), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  ent_t sched[$];
  ent_t tq[$];
  bit   tq_trapped;
  int   m_cc, m_rc;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int classify(logic [31:0] ins);
    logic [10:0] op = ins[31:21];
    if (op == 11'b10001011000) return C_ADD;
    if (op == 11'b11001011000) return C_SUB;
    if (op == 11'b10001010000) return C_AND;
    if (op == 11'b10101010000) return C_ORR;
    if (op == 11'b11111000010) return C_LDUR;
    if (op == 11'b11111000000) return C_STUR;
    if (ins[31:24] == 8'hB4)   return C_CBZ;
    if (ins[31:24] == 8'hB5)   return C_CBNZ;
    if (ins[31:26] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  function automatic logic [31:0] encode(int cls);
    logic [31:0] r = $urandom;
    case (cls)
      C_ADD:  return {11'b10001011000, r[20:0]};
      C_SUB:  return {11'b11001011000, r[20:0]};
      C_AND:  return {11'b10001010000, r[20:0]};
      C_ORR:  return {11'b10101010000, r[20:0]};
      C_LDUR: return {11'b11111000010, r[20:0]};
      C_STUR: return {11'b11111000000, r[20:0]};
      C_CBZ:  return {8'hB4, r[23:0]};
      C_CBNZ: return {8'hB5, r[23:0]};
      C_B:    return {6'b000101, r[25:0]};
      default: begin
        while (classify(r) != C_ILL) r = $urandom;
        return r;
      end
    endcase
  endfunction

  function automatic logic [3:0] alu_of(int cls);
    case (cls)
      C_ADD:   return 4'b0010;
      C_SUB:   return 4'b0110;
      C_AND:   return 4'b0000;
      default: return 4'b0001;
    endcase
  endfunction

  // Unconstrained inputs carry random noise so ignored acks are exercised too.
  function automatic ent_t mk(logic [2:0] st, logic [10:0] ctl, logic [3:0] alu, logic ret);
    ent_t e;
    e.rst = 1'b0; e.iack = 1'($urandom_range(0, 1)); e.dack = 1'($urandom_range(0, 1));
    e.z = 1'($urandom_range(0, 1)); e.ins = $urandom;
    e.st = st; e.ctl = ctl; e.alu = alu; e.ret = ret; e.trp = (st == 3'd7);
    e.cc = '0; e.rc = '0;
    return e;
  endfunction

  task automatic add_trap();
    int n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) tq.push_back(mk(3'd7, 11'h0, 4'b0000, 1'b0));
    tq_trapped = 1'b1;
  endtask

  task automatic add_mem(int ddly, logic [10:0] op, logic ret);
    ent_t e;
    for (int i = 0; i < ddly && i < TMO; i++) begin
      e = mk(3'd3, DREQ | op, 4'b0000, 1'b0); e.dack = 1'b0; tq.push_back(e);
    end
    if (ddly >= TMO) begin add_trap(); return; end
    e = mk(3'd3, DREQ | op, 4'b0000, ret); e.dack = 1'b1; tq.push_back(e);
  endtask

  task automatic build(int cls, int idly, int ddly, logic z);
    ent_t e;
    logic taken;
    tq.delete();
    tq_trapped = 1'b0;
    for (int i = 0; i < idly && i < TMO; i++) begin
      e = mk(3'd0, IREQ, 4'b0000, 1'b0); e.iack = 1'b0; tq.push_back(e);
    end
    if (idly >= TMO) begin add_trap(); return; end
    e = mk(3'd0, IREQ | IRW | PCW, 4'b0000, 1'b0); e.iack = 1'b1; e.ins = encode(cls);
    tq.push_back(e);
    tq.push_back(mk(3'd1, 11'h0, 4'b0000, 1'b0));
    case (cls)
      C_ADD, C_SUB, C_AND, C_ORR: begin
        tq.push_back(mk(3'd2, 11'h0, alu_of(cls), 1'b0));
        tq.push_back(mk(3'd4, RW, 4'b0000, 1'b1));
      end
      C_LDUR: begin
        tq.push_back(mk(3'd2, ASRC, 4'b0010, 1'b0));
        add_mem(ddly, MRD, 1'b0);
        if (!tq_trapped) tq.push_back(mk(3'd4, RW | M2R, 4'b0000, 1'b1));
      end
      C_STUR: begin
        tq.push_back(mk(3'd2, ASRC | R2L, 4'b0010, 1'b0));
        add_mem(ddly, MWR, 1'b1);
      end
      C_CBZ, C_CBNZ: begin
        taken = (cls == C_CBZ) ? z : ~z;
        e = mk(3'd2, R2L | (taken ? (PCW | PCS) : 11'h0), 4'b0111, 1'b1);
        e.z = z;
        tq.push_back(e);
      end
      C_B: tq.push_back(mk(3'd2, PCW | PCS, 4'b0000, 1'b1));
      default: add_trap();
    endcase
  endtask

  task automatic emit(ent_t e);
    if (e.rst) begin
      e.st = 3'd0; e.ctl = 11'h0; e.alu = 4'b0000; e.ret = 1'b0; e.trp = 1'b0;
      e.cc = '0; e.rc = '0;
      sched.push_back(e);
      m_cc = 0; m_rc = 0;
    end else begin
`ifdef MC_CTRL_PERF_EN
      e.cc = m_cc; e.rc = m_rc;
`endif
      sched.push_back(e);
      if (e.st != 3'd7) m_cc++;
      if (e.ret) m_rc++;
    end
  endtask

  task automatic emit_reset();
    ent_t e = mk(3'd0, 11'h0, 4'b0000, 1'b0);
    e.rst = 1'b1;
    emit(e);
  endtask

  task automatic commit(bit allow_cut);
    int k;
    if (tq_trapped) begin
      foreach (tq[i]) emit(tq[i]);
      emit_reset();
    end else if (allow_cut && tq.size() > 1 && $urandom_range(0, 7) == 0) begin
      k = $urandom_range(1, tq.size() - 1);
      for (int i = 0; i < k; i++) emit(tq[i]);
      emit_reset();
    end else begin
      foreach (tq[i]) emit(tq[i]);
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int count_ctl(logic [10:0] m);
    int n = 0;
    foreach (tq[i]) if ((tq[i].ctl & m) != 0) n++;
    return n;
  endfunction

  function automatic int ret_idx();
    foreach (tq[i]) if (tq[i].ret) return i;
    return -1;
  endfunction

  task automatic directed();
    emit_reset(); emit_reset();
    build(C_ADD, 0, 0, 1'b0);
    tq[0].ins = 32'h8B010002;
    chk("add_len", 64'(tq.size()), 64'd4);
    chk("add_states", {52'd0, tq[0].st, tq[1].st, tq[2].st, tq[3].st}, 64'o0124);
    chk("add_alu", 64'(tq[2].alu), 64'b0010);
    chk("add_wb", {62'd0, tq[3].ctl[2], tq[3].ret}, 64'b11);
    commit(1'b0);
    for (int i = 0; i < 2; i++) begin build(C_ADD, 0, 0, 1'b0); commit(1'b0); end
`ifdef MC_CTRL_PERF_EN
    chk("perf_cycles", 64'(m_cc), 64'd12);
    chk("perf_retires", 64'(m_rc), 64'd3);
`endif
    build(C_LDUR, 0, 3, 1'b0);
    chk("ldur_retire_cycle", 64'(ret_idx() + 1), 64'd8);
    chk("ldur_mem_read_cycles", 64'(count_ctl(MRD)), 64'd4);
    chk("ldur_wb", 64'(tq[7].ctl), 64'(RW | M2R));
    commit(1'b0);
    build(C_STUR, 0, 0, 1'b0);
    chk("stur_len", 64'(tq.size()), 64'd4);
    chk("stur_exec", 64'(tq[2].ctl), 64'(ASRC | R2L));
    chk("stur_reg_write", 64'(count_ctl(RW)), 64'd0);
    commit(1'b0);
    build(C_CBZ, 0, 0, 1'b1);
    chk("cbz_taken", {49'd0, tq[2].ctl, tq[2].alu}, {49'd0, PCW | PCS | R2L, 4'b0111});
    commit(1'b0);
    build(C_CBZ, 0, 0, 1'b0);  chk("cbz_not_taken", 64'(tq[2].ctl), 64'(R2L)); commit(1'b0);
    build(C_CBNZ, 0, 0, 1'b0); chk("cbnz_taken", 64'(tq[2].ctl), 64'(PCW | PCS | R2L)); commit(1'b0);
    build(C_CBNZ, 0, 0, 1'b1); chk("cbnz_not_taken", 64'(tq[2].ctl), 64'(R2L)); commit(1'b0);
    build(C_B, 0, 0, 1'b0);    chk("b_len", 64'(tq.size()), 64'd3); commit(1'b0);
    build(C_ILL, 0, 0, 1'b0);
    tq[0].ins = 32'hFFFFFFFF;
    chk("ill_trap_after_decode", {61'd0, tq[2].st}, 64'd7);
    commit(1'b0);
    build(C_ADD, 20, 0, 1'b0);
    chk("imem_timeout", {58'd0, tq[15].st, tq[16].st}, 64'o07);
    commit(1'b0);
    build(C_ADD, 15, 0, 1'b0);
    chk("imem_ack_at_expiry", 64'(tq[15].ctl), 64'(IREQ | IRW | PCW));
    commit(1'b0);
    build(C_STUR, 0, 20, 1'b0);
    commit(1'b0);
    build(C_LDUR, 0, 3, 1'b0);
    for (int i = 0; i < 4; i++) emit(tq[i]);
    emit_reset();
    build(C_ADD, 0, 0, 1'b0);
    commit(1'b0);
  endtask

  function automatic int rnd_dly();
    int p = $urandom_range(0, 9);
    if (p < 7) return 0;
    if (p < 9) return $urandom_range(1, 4);
    return $urandom_range(13, 18);
  endfunction

  initial begin
    ent_t e;
    logic [10:0] act;
    m_cc = 0; m_rc = 0;
    bus.instr = '0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    directed();
    for (int n = 0; n < 300; n++) begin
      int cls = ($urandom_range(0, 19) == 0) ? C_ILL : $urandom_range(C_ADD, C_B);
      build(cls, rnd_dly(), rnd_dly(), 1'($urandom_range(0, 1)));
      commit(1'b1);
    end
    emit_reset();
    foreach (sched[c]) begin
      e = sched[c];
      @(posedge clk);
      #1;
      reset = e.rst; bus.imem_ack = e.iack; bus.dmem_ack = e.dack;
      bus.instr = e.ins; zero = e.z;
      @(negedge clk);
      act = {bus.imem_req, bus.dmem_req, ir_write, pc_write, pc_src, reg2loc,
             alu_src, mem2reg, reg_write, mem_read, mem_write};
      n_vec++;
      if ({state, act, alu_signal, retire, trap} !== {e.st, e.ctl, e.alu, e.ret, e.trp}) begin
        n_err++;
        $display("FAIL outputs cyc %0d: got st=%0d ctl=%h alu=%b ret=%b trap=%b, want st=%0d ctl=%h alu=%b ret=%b trap=%b",
                 c, state, act, alu_signal, retire, trap, e.st, e.ctl, e.alu, e.ret, e.trp);
      end
      n_vec++;
      if ({cycle_count, retire_count} !== {e.cc, e.rc}) begin
        n_err++;
        $display("FAIL counters cyc %0d: got cycles=%0d retires=%0d, want cycles=%0d retires=%0d",
                 c, cycle_count, retire_count, e.cc, e.rc);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
